lvt_multiport_ram: RTL
======================

Name: lvt_multiport_ram

Overview:
- Parametrised multi-port RAM with separate counts of write ports and read ports, built as a live-value-table (LVT) memory.
- Adds four things the previous single-count LVT memory lacked:
  - a synchronous clear sequence after reset;
  - deterministic write-conflict resolution with a conflict flag;
  - an optional same-cycle write-to-read bypass;
  - an optional output register stage.
- Used as a register file and scratch memory wherever several producers and consumers share one store in a single clock domain.

Parameters:
- WIDTH, 32: data width in bits.
- DEPTH, 64: number of entries, >= 2. Need not be a power of two.
- WR_PORTS, 2: number of write ports, >= 1.
- RD_PORTS, 2: number of read ports, >= 1.
- BYPASS, 1: 1 = a read of an address written in the same cycle returns the new data; 0 = it returns the old data.
- OUT_REG, 0: 1 = adds an output register; read latency becomes 2 cycles instead of 1.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- ready  out  1  high when the clear sequence is finished and ports are accepted.
- conflict  out  1  one-cycle flag: two or more accepted writes targeted the same address.
- waddr  in  $clog2(DEPTH) x WR_PORTS  write addresses, unpacked array.
- wen  in  1 x WR_PORTS  write enables.
- wdata  in  WIDTH x WR_PORTS  write data.
- raddr  in  $clog2(DEPTH) x RD_PORTS  read addresses.
- ren  in  1 x RD_PORTS  read enables.
- rdata  out  WIDTH x RD_PORTS  read data.
- rvalid  out  1 x RD_PORTS  qualifies rdata.

Behaviour:
- Reset (rst_n sampled low at an edge):
  - state <= CLEAR, clear counter <= 0.
  - ready, conflict and all rvalid <= 0.
  - rdata <= 0, including any OUT_REG pipeline stage.
  - Reset wins over everything, including a clear in progress or reads in flight.
- State CLEAR:
  - At each edge with rst_n high, entry[cnt] <= 0 and cnt <= cnt + 1.
  - When entry DEPTH-1 is written, state <= RUN and ready <= 1.
  - ready therefore rises exactly DEPTH edges after the first edge with rst_n high.
  - wen and ren are ignored; rvalid stays 0.
  - A reset mid-clear restarts at cnt 0.
- State RUN:
  - RUN is held until the next reset.
  - A write is accepted when ready and wen[p] are both high.
  - A read is accepted when ready and ren[r] are both high.
- Read latency:
  - OUT_REG=0: rdata[r] and rvalid[r] update at the edge that accepts the read, i.e. they are valid in the following cycle.
  - OUT_REG=1: one additional cycle.
  - rvalid[r] = the accept, delayed by the latency.
  - rdata holds its last value when rvalid is 0.
- Read value: the most recent accepted write to raddr[r], or 0 if the address has not been written since clear.
- Same-cycle write and read to the same address:
  - BYPASS=1 returns the write data.
  - BYPASS=0 returns the prior contents.
- Write conflict:
  - If several accepted writes hit one address in a cycle, the highest-index port wins.
  - conflict <= 1 for exactly the following cycle.
  - Writes to different addresses all commit.
  - With BYPASS=1, a read of the contested address returns the winner's data.
- Any number of read ports may read any addresses concurrently, with no stalls.
- Every read-port/write-port combination has full throughput: one access per port per cycle.
- Out-of-range addresses (>= DEPTH): the write is dropped and the read returns 0. Neither is flagged.
- Implementation:
  - WR_PORTS x RD_PORTS banks, each with one write and one read port.
  - An LVT of width $clog2(WR_PORTS) selects the bank, or a single bank when WR_PORTS=1.
  - The clear sequence must leave the LVT and at least the LVT-selected bank consistent.

Test Plan:
- Clear check, DEPTH=64: release rst_n, hold ren high on all ports.
  - ready goes 1 exactly 64 edges later, and rvalid stays 0 until then.
  - Afterwards, reading addresses 0..63 returns 0.
- Basic write/read: write port 1 writes 0xDEADBEEF to address 5, and the next cycle read port 0 reads address 5.
  - rdata[0] = 0xDEADBEEF and rvalid[0]=1 one cycle later; with OUT_REG=1, two cycles later.
- Conflict: ports 0 and 1 write 0x11 and 0x22 to address 9 in the same cycle.
  - conflict=1 for one cycle.
  - A later read of address 9 returns 0x22.
- Bypass: write 0xAA to address 3 while reading address 3 in the same cycle, after a prior value of 0x55.
  - BYPASS=1 returns 0xAA.
  - BYPASS=0 returns 0x55, and the next read returns 0xAA.
- Reset mid-clear and mid-run:
  - Assert rst_n=0 at clear count 20: ready stays 0 and the full 64-cycle clear restarts.
  - Assert rst_n=0 while a read is in flight: rvalid=0 and rdata=0 at the next edge.
- Concurrency stress, WR_PORTS=3, RD_PORTS=4, DEPTH=48: random traffic to distinct and colliding addresses, compared against a reference model.
  - No mismatches.
  - Addresses 48..63 are written but never change stored state.

Source files
------------

// File: rtl/lvt_multiport_ram.sv
// Multi-port RAM built from 1W1R banks steered by a live-value table (LVT).
// Adds a post-reset clear sweep, highest-port-wins conflict handling, bypass and output register.
module lvt_multiport_ram #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned WR_PORTS = 2,
  parameter int unsigned RD_PORTS = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned OUT_REG  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     ready,
  output logic                     conflict,
  input  logic [$clog2(DEPTH)-1:0] waddr [WR_PORTS],
  input  logic [WR_PORTS-1:0]      wen,
  input  logic [WIDTH-1:0]         wdata [WR_PORTS],
  input  logic [$clog2(DEPTH)-1:0] raddr [RD_PORTS],
  input  logic [RD_PORTS-1:0]      ren,
  output logic [WIDTH-1:0]         rdata [RD_PORTS],
  output logic [RD_PORTS-1:0]      rvalid
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = (WR_PORTS > 1) ? $clog2(WR_PORTS) : 1;

  typedef enum logic {StClear, StRun} state_e;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          conflict_q, conflict_d;

  // bank_mem[p][r] holds every write of port p, replicated once per read port.
  logic [WIDTH-1:0] bank_mem [WR_PORTS][RD_PORTS][DEPTH];
  logic [LW-1:0]    lvt_mem  [DEPTH];

  logic [WR_PORTS-1:0] wr_acc;
  logic [WR_PORTS-1:0] wr_win;
  logic                clr;
  logic [WR_PORTS-1:0] mem_we;
  logic [WR_PORTS-1:0] lvt_we;
  logic [AW-1:0]       mem_addr  [WR_PORTS];
  logic [WIDTH-1:0]    mem_wdata [WR_PORTS];

  logic [RD_PORTS-1:0] rd_acc;
  logic [WIDTH-1:0]    rd_val     [RD_PORTS];
  logic [WIDTH-1:0]    s1_data_q  [RD_PORTS];
  logic [WIDTH-1:0]    s1_data_d  [RD_PORTS];
  logic [RD_PORTS-1:0] s1_valid_q, s1_valid_d;

  // Control FSM: sweep every entry once after reset, then run until the next reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    if (state_q == StClear) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == AW'(DEPTH - 1)) begin
        state_d = StRun;
        ready_d = 1'b1;
        cnt_d   = '0;
      end
    end
  end

  // Write acceptance; a port loses to any higher-index port targeting the same address.
  always_comb begin
    wr_acc = '0;
    for (int unsigned p = 0; p < WR_PORTS; p++) begin
      wr_acc[p] = ready_q & wen[p] & in_range(waddr[p]);
    end
    wr_win = wr_acc;
    for (int unsigned p = 0; p < WR_PORTS; p++) begin
      for (int unsigned q = p + 1; q < WR_PORTS; q++) begin
        if (wr_acc[q] && (waddr[q] == waddr[p])) begin
          wr_win[p] = 1'b0;
        end
      end
    end
    conflict_d = |(wr_acc & ~wr_win);
  end

  // Bank/LVT write ports; the clear sweep zeroes all banks and points the LVT at bank 0.
  always_comb begin
    clr    = (state_q == StClear) && rst_n;
    lvt_we = wr_win;
    for (int unsigned p = 0; p < WR_PORTS; p++) begin
      mem_we[p]    = clr | wr_win[p];
      mem_addr[p]  = clr ? cnt_q : waddr[p];
      mem_wdata[p] = clr ? '0 : wdata[p];
    end
    if (clr) begin
      lvt_we    = '0;
      lvt_we[0] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < WR_PORTS; p++) begin
      if (mem_we[p]) begin
        for (int unsigned r = 0; r < RD_PORTS; r++) begin
          bank_mem[p][r][mem_addr[p]] <= mem_wdata[p];
        end
      end
      if (lvt_we[p]) begin
        lvt_mem[mem_addr[p]] <= LW'(p);
      end
    end
  end

  // Read path: LVT picks the bank; with bypass the winning same-cycle write overrides it.
  always_comb begin
    for (int unsigned r = 0; r < RD_PORTS; r++) begin
      rd_acc[r] = ready_q & ren[r];
      rd_val[r] = '0;
      if (in_range(raddr[r])) begin
        rd_val[r] = bank_mem[lvt_mem[raddr[r]]][r][raddr[r]];
        if (BYPASS != 0) begin
          for (int unsigned p = 0; p < WR_PORTS; p++) begin
            if (wr_win[p] && (waddr[p] == raddr[r])) begin
              rd_val[r] = wdata[p];
            end
          end
        end
      end
    end
  end

  always_comb begin
    s1_valid_d = rd_acc;
    for (int unsigned r = 0; r < RD_PORTS; r++) begin
      s1_data_d[r] = rd_acc[r] ? rd_val[r] : s1_data_q[r];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StClear;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      conflict_q <= 1'b0;
      s1_valid_q <= '0;
      for (int unsigned r = 0; r < RD_PORTS; r++) begin
        s1_data_q[r] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      conflict_q <= conflict_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [WIDTH-1:0]    out_data_q [RD_PORTS];
    logic [WIDTH-1:0]    out_data_d [RD_PORTS];
    logic [RD_PORTS-1:0] out_valid_q, out_valid_d;

    always_comb begin
      out_valid_d = s1_valid_q;
      for (int unsigned r = 0; r < RD_PORTS; r++) begin
        out_data_d[r] = s1_valid_q[r] ? s1_data_q[r] : out_data_q[r];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_valid_q <= '0;
        for (int unsigned r = 0; r < RD_PORTS; r++) begin
          out_data_q[r] <= '0;
        end
      end else begin
        out_valid_q <= out_valid_d;
        out_data_q  <= out_data_d;
      end
    end

    assign rdata  = out_data_q;
    assign rvalid = out_valid_q;
  end else begin : g_no_out_reg
    assign rdata  = s1_data_q;
    assign rvalid = s1_valid_q;
  end

  assign ready    = ready_q;
  assign conflict = conflict_q;

endmodule
